// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one external combinational 32-bit ALU.
// Requests are arbitrated (round-robin or fixed priority), the operands are registered and
// drive the ALU for one cycle, and the result/flags come back on one tagged response channel.
// Per-requester saturating grant counters are provided for performance monitoring.
module alu_share_arbiter #(
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 16,
    parameter int PRIO_FIXED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    input  logic [3:0]       req_sel0,
    input  logic [3:0]       req_sel1,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_sel,
    input  logic [31:0]      alu_res,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_z,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic             rsp_err,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic             rr_ptr_reg;
    logic [31:0]      op_a_reg;
    logic [31:0]      op_b_reg;
    logic [3:0]       op_sel_reg;
    logic [TAG_W-1:0] op_tag_reg;
    logic             op_id_reg;

    logic [31:0]      rsp_result_reg;
    logic             rsp_z_reg;
    logic             rsp_c_reg;
    logic             rsp_v_reg;
    logic             rsp_err_reg;
    logic             rsp_id_reg;
    logic [TAG_W-1:0] rsp_tag_reg;

    logic             winner;
    logic             can_accept;
    logic [1:0]       grant;
    logic             accept;
    logic             op_legal;

    // Only these op selects are implemented by the ALU; anything else is reported as an error.
    function automatic logic sel_is_legal(input logic [3:0] sel);
        case (sel)
            4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1111: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    assign op_legal = sel_is_legal(op_sel_reg);

    // Arbitration: pick a winner from the valid bits and pointer only, then gate by FSM state.
    always_comb begin
        winner = 1'b0;
        case (req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = (PRIO_FIXED != 0) ? 1'b0 : rr_ptr_reg;
            default: winner = 1'b0;
        endcase
        can_accept = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
        grant = 2'b00;
        if (can_accept && (req_valid != 2'b00)) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP drains or chains back-to-back.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = accept ? EXEC : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latch the winning request's operands and advance the round-robin pointer on every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            op_sel_reg <= '0;
            op_tag_reg <= '0;
            op_id_reg  <= 1'b0;
            rr_ptr_reg <= 1'b0;
        end else if (accept) begin
            op_a_reg   <= winner ? req_a1   : req_a0;
            op_b_reg   <= winner ? req_b1   : req_b0;
            op_sel_reg <= winner ? req_sel1 : req_sel0;
            op_tag_reg <= winner ? req_tag1 : req_tag0;
            op_id_reg  <= winner;
            rr_ptr_reg <= ~winner;
        end
    end

    // Capture the ALU outputs at the end of EXEC; illegal ops get a fixed error response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_reg <= '0;
            rsp_z_reg      <= 1'b0;
            rsp_c_reg      <= 1'b0;
            rsp_v_reg      <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_tag_reg    <= '0;
        end else if (state_reg == EXEC) begin
            rsp_result_reg <= op_legal ? alu_res : 32'd0;
            rsp_z_reg      <= op_legal ? alu_z : 1'b1;
            rsp_c_reg      <= op_legal & alu_c;
            rsp_v_reg      <= op_legal & alu_v;
            rsp_err_reg    <= ~op_legal;
            rsp_id_reg     <= op_id_reg;
            rsp_tag_reg    <= op_tag_reg;
        end
    end

    // One saturating grant counter per requester.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            // Count accepted ops from this requester, sticking at all-ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (grant[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign grant_cnt0 = g_cnt[0].cnt_reg;
    assign grant_cnt1 = g_cnt[1].cnt_reg;

    assign alu_a      = op_a_reg;
    assign alu_b      = op_b_reg;
    assign alu_sel    = op_sel_reg;

    assign rsp_valid  = (state_reg == RESP);
    assign rsp_result = rsp_result_reg;
    assign rsp_z      = rsp_z_reg;
    assign rsp_c      = rsp_c_reg;
    assign rsp_v      = rsp_v_reg;
    assign rsp_err    = rsp_err_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_tag    = rsp_tag_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level queue model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [3:0]  req_sel0, req_sel1, req_tag0, req_tag1;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_sel;
    logic        alu_z, alu_c, alu_v;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_z, rsp_c, rsp_v, rsp_err, rsp_id;
    logic [3:0]  rsp_tag;
    logic [15:0] grant_cnt0, grant_cnt1;

    // second instance: 2-bit counters, fixed priority
    logic [1:0]  sat_req_valid;
    logic [1:0]  sat_req_ready;
    logic [31:0] sat_alu_a, sat_alu_b, sat_alu_res;
    logic [3:0]  sat_alu_sel;
    logic        sat_alu_z, sat_alu_c, sat_alu_v;
    logic        sat_rsp_valid, sat_rsp_ready;
    logic [31:0] sat_rsp_result;
    logic        sat_rsp_z, sat_rsp_c, sat_rsp_v, sat_rsp_err, sat_rsp_id;
    logic [3:0]  sat_rsp_tag;
    logic [1:0]  sat_cnt0, sat_cnt1;

    int checks = 0;
    int errors = 0;
    int cnt_exp [2];

    always #5 clk = ~clk;

    alu_share_arbiter #(.TAG_W(4), .CNT_W(16), .PRIO_FIXED(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_sel0(req_sel0), .req_sel1(req_sel1), .req_tag0(req_tag0), .req_tag1(req_tag1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_err(rsp_err),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_share_arbiter #(.TAG_W(4), .CNT_W(2), .PRIO_FIXED(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(sat_req_valid), .req_ready(sat_req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_sel0(req_sel0), .req_sel1(req_sel1), .req_tag0(req_tag0), .req_tag1(req_tag1),
        .alu_a(sat_alu_a), .alu_b(sat_alu_b), .alu_sel(sat_alu_sel), .alu_res(sat_alu_res),
        .alu_z(sat_alu_z), .alu_c(sat_alu_c), .alu_v(sat_alu_v),
        .rsp_valid(sat_rsp_valid), .rsp_ready(sat_rsp_ready), .rsp_result(sat_rsp_result),
        .rsp_z(sat_rsp_z), .rsp_c(sat_rsp_c), .rsp_v(sat_rsp_v), .rsp_err(sat_rsp_err),
        .rsp_id(sat_rsp_id), .rsp_tag(sat_rsp_tag), .grant_cnt0(sat_cnt0), .grant_cnt1(sat_cnt1)
    );

    // External ALU: {result, z, c, v}. Unimplemented selects return garbage on purpose.
    function automatic logic [34:0] alu_fn(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (sel)
            4'b0000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                           v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0001: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b0100: r = a | b;
            4'b0101: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1000: r = a << b[4:0];
            4'b1001: r = a >> b[4:0];
            4'b1010: r = $signed(a) >>> b[4:0];
            4'b1101: r = a & b;
            4'b1111: r = {31'd0, ($signed(a) < $signed(b))};
            default: return {32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1};
        endcase
        return {r, (r == 32'd0), c, v};
    endfunction

    assign {alu_res, alu_z, alu_c, alu_v}             = alu_fn(alu_sel, alu_a, alu_b);
    assign {sat_alu_res, sat_alu_z, sat_alu_c, sat_alu_v} = alu_fn(sat_alu_sel, sat_alu_a, sat_alu_b);

    // Expected response {err, result, z, c, v} from the op rules.
    function automatic logic [35:0] exp_rsp(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel inside {4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111,
                        4'b1000, 4'b1001, 4'b1010, 4'b1101, 4'b1111})
            return {1'b0, alu_fn(sel, a, b)};
        return {1'b1, 32'd0, 1'b1, 1'b0, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic put_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel, input logic [3:0] tag);
        if (r == 0) begin
            req_a0 = a; req_b0 = b; req_sel0 = sel; req_tag0 = tag;
        end else begin
            req_a1 = a; req_b1 = b; req_sel1 = sel; req_tag1 = tag;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00; sat_req_valid = 2'b00;
        rsp_ready = 1'b0;  sat_rsp_ready = 1'b0;
        cnt_exp[0] = 0; cnt_exp[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nxt();
    endtask

    typedef struct {
        logic        id;
        logic [31:0] a, b;
        logic [3:0]  sel, tag;
        logic [31:0] res;
        logic        z, c, v, err;
    } vec_t;
    vec_t vecs[$];

    // Single-op transaction from one requester with rsp_ready held high.
    task automatic run_vec(input vec_t vt);
        bit got;
        put_req(int'(vt.id), vt.a, vt.b, vt.sel, vt.tag);
        rsp_ready = 1'b1;
        req_valid = vt.id ? 2'b10 : 2'b01;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready == req_valid) begin got = 1'b1; break; end
            nxt();
        end
        chk("vec_grant", 64'(got), 64'd1);
        if (got) begin
            nxt();
            req_valid = 2'b00;
            cnt_exp[vt.id]++;
            @(negedge clk);
            chk("vec_exec_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("vec_alu_a", 64'(alu_a), 64'(vt.a));
            chk("vec_alu_b", 64'(alu_b), 64'(vt.b));
            chk("vec_alu_sel", 64'(alu_sel), 64'(vt.sel));
            nxt();
            @(negedge clk);
            chk("vec_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("vec_result", 64'(rsp_result), 64'(vt.res));
            chk("vec_flags_zcv_err", 64'({rsp_z, rsp_c, rsp_v, rsp_err}), 64'({vt.z, vt.c, vt.v, vt.err}));
            chk("vec_id", 64'(rsp_id), 64'(vt.id));
            chk("vec_tag", 64'(rsp_tag), 64'(vt.tag));
            chk("vec_cnt0", 64'(grant_cnt0), 64'(cnt_exp[0]));
            chk("vec_cnt1", 64'(grant_cnt1), 64'(cnt_exp[1]));
            $display("vec id=%0d sel=%b a=%h b=%h -> result=%h err=%0d tag=%0h",
                     vt.id, vt.sel, vt.a, vt.b, rsp_result, rsp_err, rsp_tag);
            nxt();
        end
    endtask

    // Random-phase model state
    typedef struct { logic [31:0] a, b; logic [3:0] sel, tag; logic id; } op_t;
    typedef struct { logic [31:0] res; logic z, c, v, err, id; logic [3:0] tag; } rsp_t;

    task automatic run_random(input int ncyc);
        op_t  hold_op [2];
        bit   hold_act [2];
        op_t  exec_op;
        bit   exec_busy;
        rsp_t rq[$];
        rsp_t t;
        int   m_ptr, win;
        bit   can;
        logic [1:0]  exp_ready;
        logic [35:0] e;
        hold_act[0] = 1'b0; hold_act[1] = 1'b0;
        exec_busy = 1'b0; m_ptr = 0;
        exec_op = '{default: '0};
        for (int i = 0; i < ncyc; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (hold_act[r] && ($urandom_range(0, 15) == 0)) begin
                    hold_act[r] = 1'b0;
                end else if (!hold_act[r] && ($urandom_range(0, 1) == 1)) begin
                    hold_act[r] = 1'b1;
                    hold_op[r].a   = $urandom;
                    hold_op[r].b   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                    hold_op[r].sel = 4'($urandom_range(0, 15));
                    hold_op[r].tag = 4'($urandom_range(0, 15));
                    hold_op[r].id  = r[0];
                end
                put_req(r, hold_op[r].a, hold_op[r].b, hold_op[r].sel, hold_op[r].tag);
            end
            req_valid = {hold_act[1], hold_act[0]};
            rsp_ready = ($urandom_range(0, 3) != 0);
            can = !exec_busy && ((rq.size() == 0) || rsp_ready);
            win = -1;
            if (can) begin
                if (hold_act[0] && hold_act[1]) win = m_ptr;
                else if (hold_act[0])           win = 0;
                else if (hold_act[1])           win = 1;
            end
            exp_ready = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
            @(negedge clk);
            chk("rand_req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rand_rsp_valid", 64'(rsp_valid), 64'(rq.size() != 0));
            if (rq.size() != 0) begin
                chk("rand_result", 64'(rsp_result), 64'(rq[0].res));
                chk("rand_flags", 64'({rsp_z, rsp_c, rsp_v, rsp_err}),
                    64'({rq[0].z, rq[0].c, rq[0].v, rq[0].err}));
                chk("rand_id_tag", 64'({rsp_id, rsp_tag}), 64'({rq[0].id, rq[0].tag}));
            end
            if (exec_busy) begin
                chk("rand_alu_ops", {alu_a, alu_b}, {exec_op.a, exec_op.b});
                chk("rand_alu_sel", 64'(alu_sel), 64'(exec_op.sel));
            end
            chk("rand_cnt0", 64'(grant_cnt0), 64'(cnt_exp[0]));
            chk("rand_cnt1", 64'(grant_cnt1), 64'(cnt_exp[1]));
            @(posedge clk);
            if ((rq.size() != 0) && rsp_ready) void'(rq.pop_front());
            if (exec_busy) begin
                e = exp_rsp(exec_op.sel, exec_op.a, exec_op.b);
                t.err = e[35]; t.res = e[34:3]; t.z = e[2]; t.c = e[1]; t.v = e[0];
                t.id = exec_op.id; t.tag = exec_op.tag;
                rq.push_back(t);
                exec_busy = 1'b0;
            end
            if (win >= 0) begin
                exec_op = hold_op[win];
                exec_busy = 1'b1;
                m_ptr = 1 - win;
                if (cnt_exp[win] < 65535) cnt_exp[win]++;
                hold_act[win] = 1'b0;
            end
            #1;
        end
        req_valid = 2'b00;
        $display("random: %0d cycles, grants req0=%0d req1=%0d", ncyc, cnt_exp[0], cnt_exp[1]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   last_cyc, nrsp;
        logic exp_id;
        req_valid = 2'b00; sat_req_valid = 2'b00;
        rsp_ready = 1'b0;  sat_rsp_ready = 1'b0;
        put_req(0, 32'd0, 32'd0, 4'd0, 4'd0);
        put_req(1, 32'd0, 32'd0, 4'd0, 4'd0);

        vecs.push_back('{1'b0, 32'd5,          32'd3,  4'b0001, 4'h2, 32'd2,          1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF,  32'd1,  4'b0000, 4'h5, 32'd0,          1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h7FFF_FFFF,  32'd1,  4'b0000, 4'h7, 32'h8000_0000,  1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'd3,          32'd5,  4'b0001, 4'h1, 32'hFFFF_FFFE,  1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'd1234,       32'd5,  4'b0011, 4'h3, 32'd0,          1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_ABCD,  32'd0,  4'b1101, 4'h4, 32'd0,          1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h77,         32'h88, 4'b1110, 4'hF, 32'd0,          1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'hF0,         32'h0F, 4'b0100, 4'h8, 32'hFF,         1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'd1,          32'd4,  4'b1000, 4'h9, 32'h10,         1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0000,  32'd4,  4'b1010, 4'h6, 32'hF800_0000,  1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'hFFFF_FFFF,  32'd1,  4'b1111, 4'hC, 32'd1,          1'b0, 1'b0, 1'b0, 1'b0});

        // Reset state, sampled while reset is held
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu", {alu_a, alu_b}, 64'd0);
        chk("rst_rsp", 64'({rsp_result, rsp_z, rsp_c, rsp_v, rsp_err, rsp_id, rsp_tag}), 64'd0);
        chk("rst_cnts", 64'({grant_cnt0, grant_cnt1}), 64'd0);
        $display("reset: rsp_valid=%0d alu_a=%h cnt0=%0d", rsp_valid, alu_a, grant_cnt0);
        do_reset();

        // Vector table (includes basic SUB example and illegal/zero-result cases)
        foreach (vecs[i]) run_vec(vecs[i]);

        // Both requesters always valid: responses alternate 0,1,0,... two cycles apart
        do_reset();
        put_req(0, 32'd10, 32'd1, 4'b0000, 4'h1);
        put_req(1, 32'd20, 32'd2, 4'b0001, 4'h9);
        req_valid = 2'b11; rsp_ready = 1'b1;
        last_cyc = -1; nrsp = 0; exp_id = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk("rr_id", 64'(rsp_id), 64'(exp_id));
                chk("rr_result", 64'(rsp_result), exp_id ? 64'd18 : 64'd11);
                if (last_cyc >= 0) chk("rr_gap", 64'(cyc - last_cyc), 64'd2);
                $display("rr cyc=%0d id=%0d result=%0d", cyc, rsp_id, rsp_result);
                last_cyc = cyc; exp_id = ~exp_id; nrsp++;
            end
            nxt();
        end
        chk("rr_count", 64'(nrsp), 64'd9);
        req_valid = 2'b00;
        repeat (4) nxt();

        // Backpressure: rsp held for 5 cycles with req1 waiting, then granted on release
        do_reset();
        put_req(0, 32'd9, 32'd4, 4'b0001, 4'h6);
        put_req(1, 32'd2, 32'd2, 4'b1101, 4'hA);
        req_valid = 2'b01; rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_grant", 64'(req_ready), 64'b01);
        nxt();
        req_valid = 2'b10;
        @(negedge clk);
        chk("bp_exec_ready", 64'(req_ready), 64'b00);
        nxt();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_rsp", 64'({rsp_result, rsp_id, rsp_tag}), 64'({32'd5, 1'b0, 4'h6}));
            chk("bp_hold_ready", 64'(req_ready), 64'b00);
            $display("bp hold %0d: rsp_valid=%0d result=%0d req_ready=%b", k, rsp_valid, rsp_result, req_ready);
            nxt();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 64'(req_ready), 64'b10);
        nxt();
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp_exec2_valid", 64'(rsp_valid), 64'd0);
        nxt();
        @(negedge clk);
        chk("bp_rsp2", 64'({rsp_valid, rsp_result, rsp_id, rsp_tag}), 64'({1'b1, 32'd2, 1'b1, 4'hA}));
        nxt();

        // Asynchronous reset while an op is in EXEC
        do_reset();
        put_req(0, 32'h1111_2222, 32'h3, 4'b0000, 4'h5);
        req_valid = 2'b01; rsp_ready = 1'b1;
        @(negedge clk);
        chk("ar_grant", 64'(req_ready), 64'b01);
        nxt();
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("ar_alu", {alu_a, alu_b}, 64'd0);
        chk("ar_sel_valid", 64'({alu_sel, rsp_valid, req_ready}), 64'd0);
        chk("ar_cnt0", 64'(grant_cnt0), 64'd0);
        $display("async reset: alu_a=%h cnt0=%0d rsp_valid=%0d", alu_a, grant_cnt0, rsp_valid);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nxt();
            @(negedge clk);
            chk("ar_no_rsp", 64'(rsp_valid), 64'd0);
        end
        nxt();
        req_valid = 2'b11;
        @(negedge clk);
        chk("ar_ptr_zero", 64'(req_ready), 64'b01);
        nxt();
        req_valid = 2'b00;
        repeat (3) nxt();

        // Saturating 2-bit counters with fixed priority on the second instance
        do_reset();
        put_req(0, 32'd7, 32'd1, 4'b0000, 4'h3);
        put_req(1, 32'd9, 32'd1, 4'b0000, 4'h4);
        sat_req_valid = 2'b11; sat_rsp_ready = 1'b1;
        nrsp = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            chk("sat_no_req1_grant", 64'(sat_req_ready[1]), 64'd0);
            if (sat_rsp_valid) begin
                nrsp++;
                chk("sat_id", 64'(sat_rsp_id), 64'd0);
                chk("sat_cnt0_running", 64'(sat_cnt0), 64'((nrsp < 3) ? nrsp : 3));
                $display("sat rsp %0d: id=%0d cnt0=%0d cnt1=%0d", nrsp, sat_rsp_id, sat_cnt0, sat_cnt1);
            end
            nxt();
        end
        chk("sat_rsp_count", 64'(nrsp >= 5), 64'd1);
        chk("sat_cnt0_final", 64'(sat_cnt0), 64'd3);
        chk("sat_cnt1_final", 64'(sat_cnt1), 64'd0);
        sat_req_valid = 2'b00;
        repeat (3) nxt();

        // Randomized traffic against the queue model
        do_reset();
        run_random(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
